// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: owner state and mux select encoding.
package dmem_arbiter_pkg;
  typedef enum logic {
    CPU_OWN  = 1'b0,
    DBG_LOCK = 1'b1
  } owner_e;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DBG = 1'b1;
endpackage

// File: rtl/dmem_mux.sv
// Routes the served requester onto the data-memory port.
module dmem_mux
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata
);
  // cpu_we arrives already gated by "CPU served", so an idle cycle shows cpu_addr with we=0
  assign mem_addr  = (sel == SEL_DBG) ? dbg_addr  : cpu_addr;
  assign mem_we    = (sel == SEL_DBG) ? dbg_we    : cpu_we;
  assign mem_wdata = (sel == SEL_DBG) ? dbg_wdata : cpu_wdata;
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (priority) and a debug
// port with bounded debug wait, and lockable debug bursts with a CPU escape cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] WAIT_TOP = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_TOP = 8'(LOCK_MAX);

  owner_e     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [7:0] lock_cnt;
  logic       dbg_srv, cpu_srv, forced;

  always_ff @(posedge clk) begin
    if (rst) state <= CPU_OWN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CPU_OWN:  if (dbg_srv && dbg_lock) state_nxt = DBG_LOCK;
      DBG_LOCK: if (!dbg_req || (dbg_srv && !dbg_lock)) state_nxt = CPU_OWN;
      default:  state_nxt = CPU_OWN;
    endcase
  end

  // forced: lock has run its full length and the CPU is waiting, so it gets one cycle
  always_comb begin
    forced  = 1'b0;
    dbg_srv = 1'b0;
    case (state)
      CPU_OWN:  dbg_srv = dbg_req && (!cpu_req || wait_cnt == WAIT_TOP);
      DBG_LOCK: begin
        forced  = cpu_req && (lock_cnt == LOCK_TOP);
        dbg_srv = dbg_req && !forced;
      end
      default:  dbg_srv = 1'b0;
    endcase
  end

  assign cpu_srv   = cpu_req && !dbg_srv;
  assign cpu_stall = cpu_req && dbg_srv;
  assign dbg_gnt   = dbg_srv;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (dbg_req && !dbg_srv)
        wait_cnt <= (wait_cnt == WAIT_TOP) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      if (state != DBG_LOCK || state_nxt != DBG_LOCK || forced)
        lock_cnt <= '0;
      else if (lock_cnt != LOCK_TOP)
        lock_cnt <= lock_cnt + 8'd1;
      dbg_rvalid <= dbg_srv && !dbg_we;
      if (dbg_srv && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

  dmem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel       (dbg_srv ? SEL_DBG : SEL_CPU),
    .cpu_we    (cpu_we && cpu_srv),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MAX_WAIT = 4, LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int errors = 0, checks = 0;
  bit m_locked;
  int m_wait, m_lcnt;
  logic m_rv;
  logic [31:0] m_rd;
  bit last_dsrv, last_csrv;
  logic obs_gnt, obs_stall;
  logic [31:0] obs_crd;

  function automatic logic [7:0] ix(input logic [31:0] a);
    return a[9:2];
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic l);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d; dbg_lock = l;
  endtask

  task automatic model_reset();
    m_locked = 0; m_wait = 0; m_lcnt = 0; m_rv = 1'b0; m_rd = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge,
  // then check the registered debug read outputs.
  task automatic step();
    bit dsrv, csrv, forced, nlock, exp_we;
    logic [31:0] ea;
    #2;
    forced = 0;
    if (!m_locked) dsrv = dbg_req && (!cpu_req || m_wait == MAX_WAIT);
    else begin
      forced = cpu_req && (m_lcnt == LOCK_MAX);
      dsrv   = dbg_req && !forced;
    end
    csrv   = cpu_req && !dsrv;
    ea     = dsrv ? dbg_addr : cpu_addr;
    exp_we = dsrv ? dbg_we : (csrv && cpu_we);
    obs_gnt = dbg_gnt; obs_stall = cpu_stall; obs_crd = cpu_rdata;
    if (!rst) begin
      chk1("dbg_gnt", dbg_gnt, dsrv);
      chk1("cpu_stall", cpu_stall, cpu_req && dsrv);
      chk1("mem_we", mem_we, exp_we);
      chk32("mem_addr", mem_addr, ea);
      if (exp_we) chk32("mem_wdata", mem_wdata, dsrv ? dbg_wdata : cpu_wdata);
      if (csrv && !cpu_we) chk32("cpu_rdata", cpu_rdata, ref_mem[ix(ea)]);
    end
    last_dsrv = dsrv; last_csrv = csrv;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_rv = dsrv && !dbg_we;
      if (m_rv) m_rd = ref_mem[ix(dbg_addr)];
      if (dsrv && dbg_we) ref_mem[ix(dbg_addr)] = dbg_wdata;
      else if (csrv && cpu_we) ref_mem[ix(cpu_addr)] = cpu_wdata;
      m_wait = (dbg_req && !dsrv) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (!m_locked) begin
        nlock  = dsrv && dbg_lock;
        m_lcnt = 0;
      end else begin
        nlock  = dbg_req && !(dsrv && !dbg_lock);
        m_lcnt = (!nlock || forced) ? 0 : ((m_lcnt < LOCK_MAX) ? m_lcnt + 1 : LOCK_MAX);
      end
      m_locked = nlock;
    end
    #1;
    chk1("dbg_rvalid", dbg_rvalid, m_rv);
    chk32("dbg_rdata", dbg_rdata, m_rd);
  endtask

  initial begin
    int k, n, cpu_cycles;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    model_reset();
    rst = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();  // idle: no grant, no stall, no write

    // Debug write then read back on an idle CPU
    set_dbg(1, 1, 32'h40, 32'hDEADBEEF, 0);
    step();
    chk1("idle_dbg_gnt", obs_gnt, 1'b1);
    set_dbg(1, 0, 32'h40, 0, 0);
    step();
    chk32("dbg_readback", dbg_rdata, 32'hDEADBEEF);
    chk1("dbg_readback_v", dbg_rvalid, 1'b1);
    set_dbg(0, 0, 0, 0, 0);
    step();

    // Starvation bound: debug wins every fifth cycle
    set_cpu(1, 0, 32'h80, 0);
    set_dbg(1, 0, 32'h44, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("starve_pattern", obs_gnt, (i % 5) == 4);
    end

    // Locked burst of four writes against a busy CPU
    k = 0; n = 0;
    while (k < 4 && n < 20) begin
      set_dbg(1, 1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), k < 3);
      step();
      if (last_dsrv) k++;
      n++;
    end
    chk32("burst_done", 32'(k), 32'd4);
    set_dbg(0, 0, 0, 0, 0);
    step();
    chk1("burst_cpu_after", obs_stall, 1'b0);
    chk32("burst_last_word", mem[ix(32'h10C)], 32'hA3);

    // Lock cap: CPU escapes once per LOCK_MAX locked cycles
    cpu_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      set_dbg(1, 1, 32'h200, $urandom, 1);
      step();
      if (!obs_stall) cpu_cycles++;
    end
    chk32("lockcap_cpu_cycles", 32'(cpu_cycles), 32'd6);
    set_dbg(0, 0, 0, 0, 0);
    set_cpu(0, 0, 0, 0);
    step();

    // Reset right after a locked debug read
    set_dbg(1, 0, 32'h40, 0, 1);
    step();
    rst = 1'b1;
    set_dbg(0, 0, 0, 0, 0);
    step();
    chk1("rst_rvalid", dbg_rvalid, 1'b0);
    chk32("rst_rdata", dbg_rdata, 32'h0);
    rst = 1'b0;
    set_cpu(1, 0, 32'h40, 0);
    set_dbg(1, 0, 32'h44, 0, 0);
    step();
    chk1("rst_cpu_first", obs_stall, 1'b0);

    // CPU load pass-through
    mem[ix(32'h20)] = 32'h12345678;
    ref_mem[ix(32'h20)] = 32'h12345678;
    set_dbg(0, 0, 0, 0, 0);
    set_cpu(1, 0, 32'h20, 0);
    step();
    chk32("cpu_load", obs_crd, 32'h12345678);

    // Random traffic; each side holds its request until served
    for (int i = 0; i < 400; i++) begin
      if (!(cpu_req && !last_csrv))
        set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 15)) << 2, $urandom);
      if (!(dbg_req && !last_dsrv))
        set_dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 15)) << 2, $urandom, $urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
